// File: rtl/fifo_ptr_mem.sv
// Storage and pointer stage of the extra-bit synchronous FIFO: data array, write/read pointers, registered read.
// Optional occupancy output `level` is built only when FIFO_LEVEL_EN is defined.
module fifo_ptr_mem #(
   parameter int MEMORY_DEPTH = 4,
   parameter int ADDRESS_SIZE = 2,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cw_en,
   input  logic                    cr_en,
   input  logic [DATA_WIDTH-1:0]   w_data,
   output logic [ADDRESS_SIZE:0]   w_ptr,
   output logic [ADDRESS_SIZE:0]   r_ptr,
   output logic                    cw_max,
   output logic [DATA_WIDTH-1:0]   r_data,
`ifdef FIFO_LEVEL_EN
   output logic [ADDRESS_SIZE:0]   level,
`endif
   output logic                    r_valid
);

   // cw_en/cr_en are single-cycle strobes already qualified by the flag stage
   // (not-full / not-empty); each high cycle moves exactly one word, no backpressure here.
   logic [DATA_WIDTH-1:0]   r_mem [MEMORY_DEPTH];
   logic [ADDRESS_SIZE:0]   r_wptr;
   logic [ADDRESS_SIZE:0]   r_rptr;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_rvalid;
   logic [ADDRESS_SIZE-1:0] w_waddr;
   logic [ADDRESS_SIZE-1:0] w_raddr;

   assign w_waddr = r_wptr[ADDRESS_SIZE-1:0];
   assign w_raddr = r_rptr[ADDRESS_SIZE-1:0];

   // Array is deliberately not reset so it can map onto plain storage.
   always_ff @(posedge clk) begin
      if (cw_en) begin
         r_mem[w_waddr] <= w_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
      end else if (cw_en) begin
         r_wptr <= r_wptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rptr   <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= cr_en;
         if (cr_en) begin
            r_rdata <= r_mem[w_raddr];
            r_rptr  <= r_rptr + 1'b1;
         end
      end
   end

   assign w_ptr   = r_wptr;
   assign r_ptr   = r_rptr;
   assign r_data  = r_rdata;
   assign r_valid = r_rvalid;
   assign cw_max  = (w_waddr == ADDRESS_SIZE'(MEMORY_DEPTH - 1));

`ifdef FIFO_LEVEL_EN
   // Extra wrap bit makes the modulo difference span 0..MEMORY_DEPTH.
   assign level = r_wptr - r_rptr;
`endif

endmodule

// File: tb/tb_fifo_ptr_mem.sv
// Directed self-checking bench for fifo_ptr_mem at default parameters.
// Level checks are compiled in only when FIFO_LEVEL_EN is defined.
module tb_fifo_ptr_mem;

   logic       clk;
   logic       rst_n;
   logic       cw_en;
   logic       cr_en;
   logic [7:0] w_data;
   logic [2:0] w_ptr;
   logic [2:0] r_ptr;
   logic       cw_max;
   logic [7:0] r_data;
   logic       r_valid;
`ifdef FIFO_LEVEL_EN
   logic [2:0] level;
`endif

   int n_vec = 0;
   int n_err = 0;

   fifo_ptr_mem #(
      .MEMORY_DEPTH(4),
      .ADDRESS_SIZE(2),
      .DATA_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cw_en(cw_en),
      .cr_en(cr_en),
      .w_data(w_data),
      .w_ptr(w_ptr),
      .r_ptr(r_ptr),
      .cw_max(cw_max),
      .r_data(r_data),
`ifdef FIFO_LEVEL_EN
      .level(level),
`endif
      .r_valid(r_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_level(input logic [2:0] exp);
`ifdef FIFO_LEVEL_EN
      chk("level", {29'd0, level}, {29'd0, exp});
`else
      if (exp > 3'd4) $display("unexpected level request %0d", exp);
`endif
   endtask

   task automatic chk_reset_vals();
      chk("rst_w_ptr", {29'd0, w_ptr}, 32'd0);
      chk("rst_r_ptr", {29'd0, r_ptr}, 32'd0);
      chk("rst_r_data", {24'd0, r_data}, 32'h00);
      chk("rst_r_valid", {31'd0, r_valid}, 32'd0);
      chk("rst_cw_max", {31'd0, cw_max}, 32'd0);
      chk_level(3'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cw_en  = 1'($urandom_range(0, 1));
         cr_en  = 1'($urandom_range(0, 1));
         w_data = 8'($urandom_range(0, 255));
         tick();
      end
      chk_reset_vals();
      cw_en  = 1'b0;
      cr_en  = 1'b0;
      rst_n  = 1'b1;
   endtask

   initial begin
      logic [2:0] exp_ptr;
      rst_n  = 1'b1;
      cw_en  = 1'b0;
      cr_en  = 1'b0;
      w_data = 8'h00;
      #2;

      // Reset with random enables toggling.
      do_reset();
      tick();

      // Fill A1..A4.
      chk("fill_cw_max_0", {31'd0, cw_max}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         cw_en  = 1'b1;
         w_data = 8'hA1 + 8'(i);
         tick();
         chk("fill_w_ptr", {29'd0, w_ptr}, 32'(i + 1));
         chk("fill_cw_max", {31'd0, cw_max}, (i == 2) ? 32'd1 : 32'd0);
         chk("fill_r_valid", {31'd0, r_valid}, 32'd0);
      end
      cw_en = 1'b0;
      chk_level(3'd4);

      // Drain: data one cycle after each cr_en edge, no bubbles.
      for (int i = 0; i < 4; i++) begin
         cr_en = 1'b1;
         tick();
         chk("drain_r_data", {24'd0, r_data}, 32'(8'hA1 + 8'(i)));
         chk("drain_r_valid", {31'd0, r_valid}, 32'd1);
         chk("drain_r_ptr", {29'd0, r_ptr}, 32'(i + 1));
      end
      cr_en = 1'b0;
      tick();
      chk("drain_idle_valid", {31'd0, r_valid}, 32'd0);
      chk("drain_hold_data", {24'd0, r_data}, 32'hA4);
      chk("drain_r_ptr_end", {29'd0, r_ptr}, 32'b100);
      chk_level(3'd0);

      // Wrap: restart from zero, ten write-then-read pairs.
      do_reset();
      tick();
      exp_ptr = 3'd0;
      for (int k = 0; k < 10; k++) begin
         cw_en  = 1'b1;
         w_data = 8'hD0 + 8'(k);
         tick();
         exp_ptr = exp_ptr + 3'd1;
         chk("wrap_w_ptr", {29'd0, w_ptr}, {29'd0, exp_ptr});
         chk("wrap_cw_max", {31'd0, cw_max}, (exp_ptr[1:0] == 2'd3) ? 32'd1 : 32'd0);
         cw_en = 1'b0;
         cr_en = 1'b1;
         tick();
         chk("wrap_r_data", {24'd0, r_data}, 32'(8'hD0 + 8'(k)));
         chk("wrap_r_ptr", {29'd0, r_ptr}, {29'd0, exp_ptr});
         cr_en = 1'b0;
      end
      chk("wrap_end_w_ptr", {29'd0, w_ptr}, 32'b010);
      chk("wrap_end_r_ptr", {29'd0, r_ptr}, 32'b010);

      // Simultaneous read and write with two entries stored.
      cw_en = 1'b1; w_data = 8'hB1; tick();
      w_data = 8'hB2; tick();
      chk_level(3'd2);
      cr_en = 1'b1; w_data = 8'hB3; tick();
      chk("sim_r_data", {24'd0, r_data}, 32'hB1);
      chk("sim_r_valid", {31'd0, r_valid}, 32'd1);
      chk("sim_w_ptr", {29'd0, w_ptr}, 32'd5);
      chk("sim_r_ptr", {29'd0, r_ptr}, 32'd3);
      chk_level(3'd2);
      cw_en = 1'b0;
      tick();
      chk("sim_r_data2", {24'd0, r_data}, 32'hB2);
      tick();
      chk("sim_r_data3", {24'd0, r_data}, 32'hB3);
      cr_en = 1'b0;
      tick();

      // Asynchronous reset while r_valid=1 and three entries held.
      cw_en = 1'b1;
      w_data = 8'hE1; tick();
      w_data = 8'hE2; tick();
      w_data = 8'hE3; tick();
      cr_en = 1'b1; w_data = 8'hE4; tick();
      chk("mid_r_valid_pre", {31'd0, r_valid}, 32'd1);
      chk("mid_r_data_pre", {24'd0, r_data}, 32'hE1);
      chk_level(3'd3);
      cw_en = 1'b0;
      cr_en = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk_reset_vals();
      tick();
      rst_n = 1'b1;
      cw_en = 1'b1; w_data = 8'hC1; tick();
      cw_en = 1'b0; cr_en = 1'b1; tick();
      chk("post_rst_r_data", {24'd0, r_data}, 32'hC1);
      chk("post_rst_r_valid", {31'd0, r_valid}, 32'd1);
      chk("post_rst_r_ptr", {29'd0, r_ptr}, 32'd1);
      cr_en = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_ptr_mem.md
# fifo_ptr_mem

Storage and pointer stage of the synchronous extra-bit FIFO: holds the data array and the write/read pointers, advancing them on the qualified enables `cw_en`/`cr_en`. Its `w_ptr`/`r_ptr` feed the flag stage, which returns `cw_en`/`cr_en`. Reads return registered data with a one-cycle valid strobe.

## Interface
- `MEMORY_DEPTH`, 4, number of entries; must equal 2^`ADDRESS_SIZE`
- `ADDRESS_SIZE`, 2, address bits; pointers are `ADDRESS_SIZE+1` bits wide (extra wrap bit)
- `DATA_WIDTH`, 8, data word width
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cw_en` in 1: qualified write enable from the flag stage, already gated by not-full
- `cr_en` in 1: qualified read enable from the flag stage, already gated by not-empty
- `w_data` in `DATA_WIDTH`: write data, sampled when `cw_en`=1
- `w_ptr` out `ADDRESS_SIZE+1`: write pointer to the flag stage
- `r_ptr` out `ADDRESS_SIZE+1`: read pointer to the flag stage
- `cw_max` out 1: write address field equals `MEMORY_DEPTH-1`
- `r_data` out `DATA_WIDTH`: registered read data
- `r_valid` out 1: one-cycle strobe, `r_data` updated this cycle
- `level` out `ADDRESS_SIZE+1`: occupancy, present only with `FIFO_LEVEL_EN`

## Operation
- Memory: `MEMORY_DEPTH` x `DATA_WIDTH` register array, not reset.
- Write: on `cw_en`=1, mem[`w_ptr[ADDRESS_SIZE-1:0]`] <= `w_data`, `w_ptr` <= `w_ptr`+1.
- Read: on `cr_en`=1, `r_data` <= mem[`r_ptr[ADDRESS_SIZE-1:0]`], `r_ptr` <= `r_ptr`+1, `r_valid` <= 1; else `r_valid` <= 0 and `r_data` holds.
- Pointer arithmetic: modulo 2^(`ADDRESS_SIZE+1`). Address field wraps `MEMORY_DEPTH-1` -> 0 and the MSB toggles, e.g. 3'b011 -> 3'b100, 3'b111 -> 3'b000.
- `cw_max`: combinational, `w_ptr[ADDRESS_SIZE-1:0]` == `MEMORY_DEPTH-1`, independent of the MSB.
- Simultaneous `cw_en` and `cr_en`: both pointers advance in the same cycle. The read returns the entry stored before this edge.
- Write/read address collision in the same cycle requires full and non-empty together. Upstream gating makes this impossible, so the block adds no bypass.
- No internal full/empty checking. Enables are trusted. An ungated `cw_en` while full overwrites the oldest entry. That is a flag-stage violation, flagged by a bench assertion only.
- Reset (any time, including mid-transfer): `w_ptr`=0, `r_ptr`=0, `r_data`=0, `r_valid`=0, `level`=0, so `cw_max`=0. Memory contents are undefined/retained. The first edge after release behaves as an empty FIFO.

## Timing
- Write-to-pointer latency: `w_ptr` updates on the edge sampling `cw_en`. The flag stage sees the new value the same cycle after that edge.
- Read latency: 1 cycle. `r_data`/`r_valid` are valid the cycle after the `cr_en` edge.
- Write-to-read: data written on edge N is readable by `cr_en` at edge N+1 at the earliest, once the flag stage deasserts empty.
- Back-to-back reads give one `r_valid` per cycle, with no bubbles.
- `cw_max` and `level` are combinational from the pointer registers. They carry no added latency.

## Configuration
- `FIFO_LEVEL_EN` defined: `level` port exists, `level` = `w_ptr` - `r_ptr` modulo 2^(`ADDRESS_SIZE+1`). Range is 0..`MEMORY_DEPTH`; 4 means full at default parameters.
- `FIFO_LEVEL_EN` undefined: no `level` port and no subtractor. All other behaviour is identical.

## Test plan
Defaults throughout (`MEMORY_DEPTH`=4, `ADDRESS_SIZE`=2, `DATA_WIDTH`=8).
- Reset: hold `rst_n`=0 with random enables -> `w_ptr`=0, `r_ptr`=0, `r_data`=8'h00, `r_valid`=0, `cw_max`=0, `level`=0.
- Fill: write 8'hA1,A2,A3,A4 on consecutive cycles -> `w_ptr` steps 1,2,3,4 (3'b100), `cw_max`=1 while `w_ptr`=3, `level`=4.
- Drain: read 4 times after the fill -> `r_data` = A1,A2,A3,A4 each one cycle after its `cr_en`, `r_valid` high for 4 cycles, `r_ptr`=3'b100, `level`=0.
- Wrap: 10 single write-then-read pairs -> `w_ptr`/`r_ptr` reach 3'b010 after wrapping 3'b111->3'b000 (MSB toggles at 3 and 7), data matches in order.
- Simultaneous: with 2 entries (B1,B2), assert `cw_en`+`cr_en` writing B3 -> `r_data`=B1, `level` stays 2, both pointers +1.
- Reset mid-operation: pulse `rst_n` low while `r_valid`=1 and `level`=3 -> outputs return to reset values asynchronously. The next write of C1 then a read returns C1.
